// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and constants for the byte-wide memory port scheduler.
// Holds the FSM state, bus owner, access width codes and the IO address prefix.
package mem_port_scheduler_pkg;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;
  typedef enum logic {OwnIc, OwnLs} owner_e;

  localparam logic [1:0] W_BYTE    = 2'b00;
  localparam logic [1:0] W_HALF    = 2'b01;
  localparam logic [1:0] W_WORD    = 2'b10;
  localparam logic [1:0] IO_PREFIX = 2'b11;

  // 2'b11 is treated as a word access.
  function automatic logic [3:0] width_bytes(input logic [1:0] w);
    logic [3:0] n;
    case (w)
      W_BYTE:  n = 4'd1;
      W_HALF:  n = 4'd2;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_arbiter.sv
// Two-way round-robin arbiter between icache and load/store buffer.
// last_grant moves only when a grant is actually taken while the core is running.
module mem_rr_arbiter
  import mem_port_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   en,
  input  logic   ic_req,
  input  logic   ls_req,
  output logic   gnt_valid,
  output owner_e gnt_owner
);

  owner_e last_q;

  always_comb begin
    gnt_valid = en && (ic_req || ls_req);
    gnt_owner = OwnIc;
    if (ic_req && ls_req) begin
      gnt_owner = (last_q == OwnIc) ? OwnLs : OwnIc;
    end else if (ls_req) begin
      gnt_owner = OwnLs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OwnIc;
    end else if (rdy && gnt_valid) begin
      last_q <= gnt_owner;
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Byte-wide RAM/IO bus scheduler for icache block fetches and LSB loads/stores.
// Define MEMSCHED_FLUSH_IFETCH_EN to let flush also abort icache fetches in flight.
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned IC_BYTES   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  uart_full,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  input  logic                  flush,
  input  logic                  ic_req,
  input  logic [31:0]           ic_addr,
  output logic                  ic_done,
  output logic [8*IC_BYTES-1:0] ic_data,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [31:0]           ls_addr,
  input  logic [1:0]            ls_width,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata
);

  localparam int unsigned CntW  = $clog2(2 * IC_BYTES);
  localparam int unsigned DataW = 8 * IC_BYTES;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d, nbytes_q, nbytes_d;
  logic [31:0]       base_q, base_d, wdata_q, wdata_d;
  logic [DataW-1:0]  buf_q, buf_d, ic_data_q, ic_data_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              gnt_valid;
  owner_e            gnt_owner;
  logic              ls_elig, abort, stall, rd_beat, wr_state;
  logic [31:0]       cur_addr, wshift;
  logic              unused_bits;

  // A pending load is held off while flush is high; stores are already committed.
  assign ls_elig = ls_req && !(flush && !ls_we);

  mem_rr_arbiter u_arb (
    .clk       (clk_in),
    .rst       (rst_in),
    .rdy       (rdy_in),
    .en        (state_q == StIdle),
    .ic_req    (ic_req),
    .ls_req    (ls_elig),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

`ifdef MEMSCHED_FLUSH_IFETCH_EN
  assign abort = flush;
`else
  assign abort = flush && (owner_q == OwnLs);
`endif

  assign cur_addr = base_q + 32'(cnt_q);
  assign wshift   = wdata_q >> {cnt_q, 3'b000};
  assign rd_beat  = (state_q == StRd) && (cnt_q < nbytes_q);
  assign wr_state = (state_q == StWr);
  assign stall    = wr_state && (cur_addr[17:16] == IO_PREFIX) && uart_full;

  assign ram_addr = (rd_beat || wr_state) ? cur_addr[ADDR_WIDTH-1:0] : '0;
  assign ram_dout = wr_state ? wshift[7:0] : 8'h00;
  assign ram_wr   = wr_state && !stall && rdy_in;
  assign ic_done  = (state_q == StDone) && (owner_q == OwnIc);
  assign ls_done  = (state_q == StDone) && (owner_q == OwnLs);
  assign ic_data  = ic_data_q;
  assign ls_rdata = ls_rdata_q;

  assign unused_bits = ^{cur_addr, wshift};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    ic_data_d  = ic_data_q;
    ls_rdata_d = ls_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          owner_d  = gnt_owner;
          base_d   = (gnt_owner == OwnIc) ? ic_addr : ls_addr;
          nbytes_d = (gnt_owner == OwnIc) ? CntW'(IC_BYTES) : CntW'(width_bytes(ls_width));
          wdata_d  = ls_wdata;
          cnt_d    = '0;
          buf_d    = '0;
          state_d  = (gnt_owner == OwnLs && ls_we) ? StWr : StRd;
        end
      end
      StRd: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          // Byte k arrives one cycle after its address, i.e. while cnt == k+1.
          if (cnt_q != '0) begin
            buf_d = buf_q | (DataW'(ram_din) << {cnt_q - 1'b1, 3'b000});
          end
          if (cnt_q == nbytes_q) begin
            state_d = StDone;
            if (owner_q == OwnIc) ic_data_d = buf_d;
            else                  ls_rdata_d = buf_d[31:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWr: begin
        if (!stall) begin
          if (cnt_q == nbytes_q - 1'b1) state_d = StDone;
          else                          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      owner_q    <= OwnIc;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      ic_data_q  <= ic_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

endmodule
